// File: rtl/key_entry_pkg.sv
// Shared types and constants for the key_entry block: FSM states, special key codes
// and keypad geometry.
package key_entry_pkg;

    typedef enum logic [1:0] {
        EMPTY  = 2'd0,
        ENTRY  = 2'd1,
        SUBMIT = 2'd2
    } state_t;

    localparam int KEYPAD_SIZE = 16;
    localparam int BCD_W       = 4;

    localparam logic [3:0] KEY_CLEAR = 4'd10;
    localparam logic [3:0] KEY_BACK  = 4'd11;
    localparam logic [3:0] KEY_ENTER = 4'd15;

    function automatic logic is_digit(input logic [3:0] code);
        return code <= 4'd9;
    endfunction

    // Codes 12..14 have no meaning on this keypad.
    function automatic logic is_unused(input logic [3:0] code);
        return (code >= 4'd12) && (code != KEY_ENTER);
    endfunction

endpackage

// File: rtl/key_event_encoder.sv
// Turns debounced key levels into single-key press events; a cycle with more than one
// newly pressed key yields no event and raises multi_press instead.
module key_event_encoder
    import key_entry_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic [KEYPAD_SIZE-1:0] keys,
    output logic                   event_valid,
    output logic [3:0]             event_code,
    output logic                   multi_press
);

    logic [KEYPAD_SIZE-1:0] keys_q;
    logic [KEYPAD_SIZE-1:0] rise;
    logic [4:0]             ones;
    logic [3:0]             code;

    // All-ones reset keeps keys held through reset release from looking like presses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            keys_q <= '1;
        end else begin
            keys_q <= keys;
        end
    end

    assign rise = keys & ~keys_q;

    always_comb begin
        ones = '0;
        code = '0;
        for (int i = 0; i < KEYPAD_SIZE; i++) begin
            if (rise[i]) begin
                ones = ones + 5'd1;
                code = 4'(i);
            end
        end
    end

    assign event_valid = (ones == 5'd1);
    assign event_code  = code;
    assign multi_press = (ones > 5'd1);

endmodule

// File: rtl/key_entry.sv
// Assembles key events into a multi-digit BCD guess and offers it over valid/ready.
// Optional reject pulse output enabled by defining KEY_ENTRY_REJECT_EN.
module key_entry
    import key_entry_pkg::*;
#(
    parameter int NUM_DIGITS = 2
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [KEYPAD_SIZE-1:0]          keys,
    output logic [BCD_W*NUM_DIGITS-1:0]     guess_bcd,
    output logic [$clog2(NUM_DIGITS+1)-1:0] digit_count,
    output logic                            guess_valid,
    input  logic                            guess_ready,
`ifdef KEY_ENTRY_REJECT_EN
    output logic                            reject,
`endif
    output state_t                          state_dbg
);

    localparam int GW = BCD_W * NUM_DIGITS;
    localparam int CW = $clog2(NUM_DIGITS + 1);
    localparam logic [CW-1:0] FULL = CW'(NUM_DIGITS);

    logic          ev_valid;
    logic [3:0]    ev_code;
    logic          multi;

    state_t        state_q, state_d;
    logic [GW-1:0] guess_q, guess_d;
    logic [CW-1:0] count_q, count_d;
`ifdef KEY_ENTRY_REJECT_EN
    logic          reject_q, reject_d;
`endif

    key_event_encoder u_enc (
        .clk         (clk),
        .rst         (rst),
        .keys        (keys),
        .event_valid (ev_valid),
        .event_code  (ev_code),
        .multi_press (multi)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= EMPTY;
            guess_q  <= '0;
            count_q  <= '0;
`ifdef KEY_ENTRY_REJECT_EN
            reject_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            guess_q  <= guess_d;
            count_q  <= count_d;
`ifdef KEY_ENTRY_REJECT_EN
            reject_q <= reject_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            EMPTY: begin
                if (ev_valid && is_digit(ev_code)) state_d = ENTRY;
            end
            ENTRY: begin
                if (ev_valid) begin
                    if (ev_code == KEY_CLEAR) state_d = EMPTY;
                    else if (ev_code == KEY_BACK && count_q == CW'(1)) state_d = EMPTY;
                    else if (ev_code == KEY_ENTER) state_d = SUBMIT;
                end
            end
            SUBMIT: begin
                if (guess_ready) state_d = EMPTY;
            end
            default: state_d = EMPTY;
        endcase
    end

    always_comb begin
        guess_d  = guess_q;
        count_d  = count_q;
`ifdef KEY_ENTRY_REJECT_EN
        reject_d = multi;
`endif
        unique case (state_q)
            EMPTY: begin
                if (ev_valid) begin
                    if (is_digit(ev_code)) begin
                        guess_d = (guess_q << BCD_W) | GW'(ev_code);
                        count_d = CW'(1);
                    end
`ifdef KEY_ENTRY_REJECT_EN
                    else if (ev_code != KEY_CLEAR) reject_d = 1'b1;
`endif
                end
            end
            ENTRY: begin
                if (ev_valid) begin
                    if (is_digit(ev_code)) begin
                        if (count_q < FULL) begin
                            guess_d = (guess_q << BCD_W) | GW'(ev_code);
                            count_d = count_q + CW'(1);
                        end
`ifdef KEY_ENTRY_REJECT_EN
                        else reject_d = 1'b1;
`endif
                    end else if (ev_code == KEY_BACK) begin
                        guess_d = guess_q >> BCD_W;
                        count_d = count_q - CW'(1);
                    end else if (ev_code == KEY_CLEAR) begin
                        guess_d = '0;
                        count_d = '0;
                    end
`ifdef KEY_ENTRY_REJECT_EN
                    else if (is_unused(ev_code)) reject_d = 1'b1;
`endif
                end
            end
            SUBMIT: begin
                // Guess is frozen here; any key event is dropped, even on the accept edge.
                if (guess_ready) begin
                    guess_d = '0;
                    count_d = '0;
                end
`ifdef KEY_ENTRY_REJECT_EN
                if (ev_valid) reject_d = 1'b1;
`endif
            end
            default: begin
                guess_d = '0;
                count_d = '0;
            end
        endcase
    end

    assign guess_bcd   = guess_q;
    assign digit_count = count_q;
    assign guess_valid = (state_q == SUBMIT);
    assign state_dbg   = state_q;
`ifdef KEY_ENTRY_REJECT_EN
    assign reject      = reject_q;
`endif

endmodule

// File: tb/tb_key_entry.sv
// Bench for key_entry: directed scenarios plus random key traffic, checked against a
// digit-list reference model and a queue of guesses expected at the handshake.
module tb_key_entry;
    import key_entry_pkg::*;

    localparam int N  = 2;
    localparam int GW = 4 * N;
    localparam int CW = $clog2(N + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [15:0]   keys = '0;
    logic          guess_ready = 1'b0;
    logic [GW-1:0] guess_bcd;
    logic [CW-1:0] digit_count;
    logic          guess_valid;
    state_t        state_dbg;
`ifdef KEY_ENTRY_REJECT_EN
    logic          reject;
`endif

    key_entry #(.NUM_DIGITS(N)) dut (
        .clk         (clk),
        .rst         (rst),
        .keys        (keys),
        .guess_bcd   (guess_bcd),
        .digit_count (digit_count),
        .guess_valid (guess_valid),
        .guess_ready (guess_ready),
`ifdef KEY_ENTRY_REJECT_EN
        .reject      (reject),
`endif
        .state_dbg   (state_dbg)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    logic [GW-1:0] exp_q[$];

    // Reference model: the guess is a list of digits, oldest first.
    int          m_digits[$];
    bit          m_submit;
    logic [15:0] m_prev;
    bit          m_reject;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [GW-1:0] model_bcd();
        int v = 0;
        foreach (m_digits[i]) v = v * 16 + m_digits[i];
        return GW'(v);
    endfunction

    task automatic model_step(input logic [15:0] k, input bit rdy);
        logic [15:0] rise;
        int n = 0;
        int code = 0;
        rise = k & ~m_prev;
        for (int i = 0; i < 16; i++) if (rise[i]) begin n++; code = i; end
        m_prev   = k;
        m_reject = 1'b0;
        if (m_submit) begin
            if (n != 0) m_reject = 1'b1;
            if (rdy) begin m_submit = 1'b0; m_digits.delete(); end
        end else if (n > 1) begin
            m_reject = 1'b1;
        end else if (n == 1) begin
            if (code <= 9) begin
                if (m_digits.size() < N) m_digits.push_back(code);
                else m_reject = 1'b1;
            end else if (code == 10) begin
                m_digits.delete();
            end else if (code == 11) begin
                if (m_digits.size() > 0) void'(m_digits.pop_back());
                else m_reject = 1'b1;
            end else if (code == 15) begin
                if (m_digits.size() > 0) begin
                    m_submit = 1'b1;
                    exp_q.push_back(model_bcd());
                end else m_reject = 1'b1;
            end else begin
                m_reject = 1'b1;
            end
        end
    endtask

    task automatic check_outputs();
        state_t exp_state;
        exp_state = m_submit ? SUBMIT : (m_digits.size() == 0 ? EMPTY : ENTRY);
        chk("guess_bcd", 32'(guess_bcd), 32'(model_bcd()));
        chk("digit_count", 32'(digit_count), 32'(m_digits.size()));
        chk("guess_valid", 32'(guess_valid), 32'(m_submit));
        chk("state", 32'(state_dbg), 32'(exp_state));
`ifdef KEY_ENTRY_REJECT_EN
        chk("reject", 32'(reject), 32'(m_reject));
`endif
    endtask

    task automatic step(input logic [15:0] k, input bit rdy);
        keys        = k;
        guess_ready = rdy;
        @(posedge clk);
        #1;
        model_step(k, rdy);
        check_outputs();
    endtask

    task automatic press(input int code);
        step(16'(1) << code, 1'b0);
        step(16'h0000, 1'b0);
    endtask

    task automatic do_reset(input logic [15:0] k);
        rst         = 1'b0;
        keys        = k;
        guess_ready = 1'b0;
        m_digits.delete();
        m_submit = 1'b0;
        m_prev   = '1;
        m_reject = 1'b0;
        exp_q.delete();
        #1;
        check_outputs();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    // Handshake monitor: inputs and outputs are stable at the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (rst && guess_valid === 1'b1 && guess_ready === 1'b1) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL handshake: got guess %0h but none expected", guess_bcd);
                end else begin
                    chk("handshake_bcd", 32'(guess_bcd), 32'(exp_q.pop_front()));
                end
            end
        end
    end

    initial begin
        logic [15:0] mask;
        int kind;
        int hold;
        #2;
        do_reset(16'h0000);

        // 4, 7, enter; hold off the consumer, then accept with a key on the accept edge.
        press(4);
        press(7);
        press(15);
        repeat (20) step(16'h0000, 1'b0);
        step(16'h0020, 1'b1);
        step(16'h0000, 1'b0);

        // Overflow, backspace, clear.
        press(1);
        press(2);
        press(3);
        press(11);
        press(10);

        // Simultaneous press and an unused key.
        step(16'h0028, 1'b0);
        step(16'h0000, 1'b0);
        press(13);

        // Held key enters once; enter on an empty buffer is rejected.
        repeat (100) step(16'h0200, 1'b0);
        step(16'h0000, 1'b0);
        press(10);
        press(15);
        press(11);

        // Reset mid-entry with key 6 held.
        press(2);
        step(16'h0040, 1'b0);
        do_reset(16'h0040);
        repeat (5) step(16'h0040, 1'b0);
        step(16'h0000, 1'b0);
        press(6);
        press(15);
        step(16'h0000, 1'b1);

        // Random traffic.
        repeat (300) begin
            kind = $urandom_range(0, 19);
            if (kind < 12)       mask = 16'(1) << $urandom_range(0, 9);
            else if (kind == 12) mask = 16'(1) << 10;
            else if (kind == 13) mask = 16'(1) << 11;
            else if (kind < 17)  mask = 16'(1) << 15;
            else if (kind == 17) mask = 16'(1) << $urandom_range(12, 14);
            else if (kind == 18) mask = (16'(1) << $urandom_range(0, 7)) | (16'(1) << $urandom_range(8, 15));
            else                 mask = 16'($urandom_range(0, 65535));
            hold = $urandom_range(1, 3);
            for (int h = 0; h < hold; h++) step(mask, $urandom_range(0, 2) == 0);
            step(16'h0000, $urandom_range(0, 2) == 0);
            if ($urandom_range(0, 49) == 0) do_reset($urandom_range(0, 1) ? mask : 16'h0000);
        end

        step(16'h0000, 1'b1);
        step(16'h0000, 1'b1);
        chk("pending_guesses", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/key_entry.md
Name: key_entry

Overview:
- Consumes the 16-bit debounced key-level vector from the keypad decoder.
- Converts key presses into single-key events and assembles a multi-digit decimal guess.
- Offers the guess to the game-logic stage over a valid/ready handshake.
- Isolates game logic from key-level timing, held keys and multi-key presses.

Parameters:
- NUM_DIGITS, 2, maximum digits in one guess (1..8).

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-low reset
- keys  input  16  debounced key levels, 1 = pressed; indices 0-9 digits, 10 clear, 11 backspace, 15 enter, 12-14 unused
- guess_bcd  output  4*NUM_DIGITS  BCD guess; newest digit in [3:0]
- digit_count  output  $clog2(NUM_DIGITS+1)  digits currently held
- guess_valid  output  1  guess offered to consumer
- guess_ready  input  1  consumer accepts guess

Behaviour:
- Clocking and reset:
  - One clock. Reset is asynchronous and active-low on rst.
  - Reset values: guess_bcd = 0, digit_count = 0, guess_valid = 0, state = EMPTY, keys_q = 16'hFFFF.
  - Resetting keys_q to all ones suppresses keys held through reset release.
- Edge detection:
  - keys_q <= keys every cycle.
  - rise = keys & ~keys_q.
  - An event exists only when popcount(rise) == 1; its code is the index of the set bit.
  - rise with zero bits: no event. rise with two or more bits: no event (simultaneous press rejected).
  - A held key produces one event only; there is no auto-repeat.
- Latency: state, buffer and outputs update at the same edge that first registers keys_q, i.e. the cycle after keys rises.
- FSM states: EMPTY, ENTRY, SUBMIT.
  - EMPTY
    - digit d: guess_bcd <= {guess_bcd[4*NUM_DIGITS-5:0], d}; count <= 1; go to ENTRY.
    - clear, backspace, enter, unused keys: no change.
  - ENTRY
    - digit with count < NUM_DIGITS: shift in; count++.
    - digit with count == NUM_DIGITS: ignored; buffer unchanged.
    - backspace: guess_bcd <= guess_bcd >> 4; count--; go to EMPTY if count becomes 0.
    - clear: guess_bcd <= 0; count <= 0; go to EMPTY.
    - enter: guess_valid <= 1; go to SUBMIT.
    - unused keys: no change.
  - SUBMIT
    - guess_valid stays high; guess_bcd and digit_count stay stable.
    - All key events are ignored, including clear.
    - On an edge with guess_valid && guess_ready: guess_valid <= 0, guess_bcd <= 0, count <= 0, go to EMPTY.
    - A key event on that same edge is dropped.
- guess_ready is don't-care outside SUBMIT.
- Reset mid-entry or mid-SUBMIT discards the guess immediately; no handshake completes.

Optional Feature:
- Macro: KEY_ENTRY_REJECT_EN.
- Defined: adds output port reject (1 bit), a one-cycle pulse aligned with the state update for:
  - a multi-key rise,
  - a digit on a full buffer,
  - enter or backspace in EMPTY,
  - an unused key,
  - any event in SUBMIT.
- Undefined: the port is absent and rejections are silent. All other behaviour is identical.

Decomposition:
- Package key_entry_pkg:
  - state enum {EMPTY, ENTRY, SUBMIT};
  - KEY_CLEAR = 10, KEY_BACK = 11, KEY_ENTER = 15;
  - KEYPAD_SIZE = 16, BCD_W = 4.
- Sub-module key_event_encoder: keys_q register, rise computation, popcount-equals-one check, 4-bit index encode. Outputs event_valid, event_code and multi_press.
- key_entry instantiates key_event_encoder and holds the FSM and digit buffer.

Test Plan:
- Press 4, release, press 7, release, press enter; hold guess_ready = 0 -> guess_bcd = 8'h47, digit_count = 2, guess_valid high and stable for 20 cycles.
- In SUBMIT, raise guess_ready for 1 cycle -> guess_valid low the next cycle, guess_bcd = 0, state EMPTY; a key pressed on the accept edge has no effect.
- Press 1, 2, 3 with NUM_DIGITS = 2 -> guess_bcd = 8'h12; then backspace -> 8'h01, count 1; clear -> 0, count 0.
- Raise keys[3] and keys[5] on the same cycle -> no change; reject pulses once when KEY_ENTRY_REJECT_EN is defined.
- Hold key 9 for 100 cycles -> exactly one digit entered; enter in EMPTY -> guess_valid stays 0.
- Assert rst low mid-entry with key 6 held, release rst -> all outputs 0; held key 6 not entered until released and pressed again.
